// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver core with mid-bit sampling, optional parity and error pulses
module uart_rx_core #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_next;
    logic             rxd_meta, rxd_s, rxd_d;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             par_err, par_err_next;
    logic [7:0]       data_next;
    logic             valid_next, ferr_next, perr_next;
    logic             par_expect;

    // Odd mode expects the inverse of the data XOR, even mode the XOR itself.
    assign par_expect = (PARITY == 1) ? ~(^shift) : (^shift);
    assign rx_busy    = (state != S_IDLE);

    // Synchronizer, edge-detect history, FSM state, datapath and output pulse registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rxd_meta      <= 1'b1;
            rxd_s         <= 1'b1;
            rxd_d         <= 1'b1;
            state         <= S_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            par_err       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rxd_meta      <= uart_rxd;
            rxd_s         <= rxd_meta;
            rxd_d         <= rxd_s;
            state         <= state_next;
            cnt           <= cnt_next;
            bit_idx       <= bit_idx_next;
            shift         <= shift_next;
            par_err       <= par_err_next;
            rx_data       <= data_next;
            rx_valid      <= valid_next;
            rx_frame_err  <= ferr_next;
            rx_parity_err <= perr_next;
        end
    end

    // Next-state and datapath decisions; pulses are one cycle because they default low.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        par_err_next = par_err;
        data_next    = rx_data;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        perr_next    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (rxd_d && !rxd_s) begin
                    state_next   = S_START;
                    bit_idx_next = '0;
                    par_err_next = 1'b0;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rxd_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rxd_s, shift[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = (PARITY == 0) ? S_STOP : S_PARITY;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt == FULL_LAST) begin
                    cnt_next     = '0;
                    par_err_next = (rxd_s != par_expect);
                    state_next   = S_STOP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == FULL_LAST) begin
                    // Leave mid stop bit so the next start edge can be caught.
                    cnt_next   = '0;
                    state_next = S_IDLE;
                    ferr_next  = !rxd_s;
                    perr_next  = par_err;
                    if (rxd_s && !par_err) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, giving the sys_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, giving the line bit rate in bit/s.
REQ-003 The block SHALL have parameter PARITY, default 0, selecting parity mode: 0 none, 1 odd, 2 even.
REQ-004 The block SHALL have port sys_clk  input  1  as its single clock; all logic SHALL be rising-edge sys_clk.
REQ-005 The block SHALL have port sys_rst  input  1  as its reset, which SHALL be synchronous and active-high.
REQ-006 The block SHALL have port uart_rxd  input  1  carrying the asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data  output  8  holding the last correctly received byte.
REQ-008 The block SHALL have port rx_valid  output  1  as a one-cycle pulse marking a new good byte on rx_data.
REQ-009 The block SHALL have port rx_frame_err  output  1  as a one-cycle pulse marking a stop bit sampled low.
REQ-010 The block SHALL have port rx_parity_err  output  1  as a one-cycle pulse marking a parity mismatch (never asserted when PARITY=0).
REQ-011 The block SHALL have port rx_busy  output  1, high whenever the FSM is not in IDLE.

Function
REQ-012 uart_rxd SHALL pass through a 2-flop synchronizer, with both flops set to 1 by reset; all decisions SHALL use the synchronized value (rxd_s) and a third flop holding its previous value (rxd_d).
REQ-013 BAUD_DIV SHALL be CLK_FREQ/BAUD_RATE using integer truncation; the baud counter SHALL be wide enough for BAUD_DIV-1.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-015 PARITY state SHALL be skipped when PARITY=0.
REQ-016 In IDLE, a falling edge (rxd_d=1, rxd_s=0) SHALL move to START and clear the baud counter.
REQ-017 A line held low SHALL NOT retrigger, because IDLE requires a falling edge.
REQ-018 In START, when the counter reaches BAUD_DIV/2-1, rxd_s SHALL be sampled: 0 moves to DATA with the counter cleared; 1 (glitch) returns to IDLE with no output pulse.
REQ-019 In DATA, PARITY and STOP, a bit SHALL be sampled each time the counter reaches BAUD_DIV-1, after which the counter clears (mid-bit sampling).
REQ-020 DATA SHALL shift in 8 bits LSB first and use a 3-bit index.
REQ-021 After the 8th data bit, the FSM SHALL go to PARITY, or to STOP if PARITY=0.
REQ-022 In PARITY, the sampled bit SHALL be compared with the XOR of the data bits (even) or its inverse (odd), and the mismatch flag latched.
REQ-023 At the STOP sample, the block SHALL go to IDLE on the next cycle (mid stop bit, allowing resync for the next frame).
REQ-024 On the cycle after the STOP sample, if stop=1 and no parity mismatch: rx_data SHALL load the shifted byte and rx_valid SHALL pulse.
REQ-025 On the cycle after the STOP sample, if stop=0: rx_frame_err SHALL pulse.
REQ-026 On the cycle after the STOP sample, if a parity mismatch is latched: rx_parity_err SHALL pulse; both error pulses MAY coincide.
REQ-027 On any error, rx_valid SHALL stay 0 and rx_data SHALL keep its previous value.
REQ-028 Back-to-back frames SHALL be received with zero idle bits between the stop bit and the next start bit.
REQ-029 Each output pulse SHALL last exactly one sys_clk cycle.

Reset
REQ-030 While sys_rst=1 at a sys_clk edge, the block SHALL set: FSM to IDLE, counters and shift register to 0, synchronizer flops to 1, rx_data to 0x00, and rx_valid, rx_frame_err, rx_parity_err, rx_busy to 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-032 After reset is released, the block SHALL wait for a fresh falling edge.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, BAUD_DIV=10 unless noted)
REQ-033 The bench SHALL cover: frame 0x96 (8N1) -> single rx_valid pulse, rx_data=0x96, no error pulses, rx_busy low afterwards.
REQ-034 The bench SHALL cover: low glitch of 3 cycles on idle line -> returns to IDLE by START sample, no pulses, rx_data unchanged.
REQ-035 The bench SHALL cover: frame 0x5A with stop bit driven 0 -> rx_frame_err pulse, no rx_valid, rx_data keeps prior 0x96.
REQ-036 The bench SHALL cover: PARITY=2, frame 0x96 with parity bit 1 (correct 0) -> rx_parity_err pulse, no rx_valid; same frame with parity 0 -> rx_valid, rx_data=0x96.
REQ-037 The bench SHALL cover: sys_rst pulsed for 1 cycle during data bit 4 -> all outputs 0, no pulse for the aborted frame; next full frame 0xA5 -> rx_valid, rx_data=0xA5.
REQ-038 The bench SHALL cover: back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses 100 cycles apart, rx_data 0x00 then 0xFF.
